// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, FSM encoding, reset PC.
package instr_fetch_pkg;

    localparam int unsigned WordWidth = 32;

    localparam logic [WordWidth-1:0] DefaultResetPc = '0;

    typedef enum logic [1:0] {
        FetchBoot   = 2'd0,
        FetchRun    = 2'd1,
        FetchHalted = 2'd2
    } fetch_state_e;

    // Address arithmetic wraps modulo 2^WordWidth by construction.
    function automatic logic [WordWidth-1:0] pc_inc(input logic [WordWidth-1:0] pc,
                                                    input logic [WordWidth-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, control inputs and the IF/ID handshake to decode.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [WordWidth-1:0] imem_addr;
    logic [WordWidth-1:0] imem_instr;
    logic                 redirect_valid;
    logic [WordWidth-1:0] redirect_pc;
    logic                 halt_req;
    logic                 resume;
    logic                 id_ready;
    logic                 if_valid;
    logic [WordWidth-1:0] if_instr;
    logic [WordWidth-1:0] if_pc;
    logic [WordWidth-1:0] if_pc_next;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, if_pc_next,
        input  imem_instr, redirect_valid, redirect_pc, halt_req, resume, id_ready
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, if_pc_next,
        output imem_instr, redirect_valid, redirect_pc, halt_req, resume, id_ready
    );

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// Valid/ready pipeline holding register for instr/pc/pc_next with flush; reusable between stages.
module if_id_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             ready_i,
    input  logic [Width-1:0] instr_i,
    input  logic [Width-1:0] pc_i,
    input  logic [Width-1:0] pc_next_i,
    output logic             valid_o,
    output logic [Width-1:0] instr_o,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] pc_next_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] instr_q, pc_q, pc_next_q;

    // Flush wins over a new load; an unreplaced entry drains when consumed.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i && !flush_i) begin
                instr_q   <= instr_i;
                pc_q      <= pc_i;
                pc_next_q <= pc_next_i;
            end
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, fills the IF/ID register.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [WordWidth-1:0] RESET_PC = DefaultResetPc,
    parameter logic [WordWidth-1:0] PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_if.master       bus,
    output logic [1:0]          fetch_state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched_o,
    output logic [31:0]         perf_stall_o,
    output logic [15:0]         perf_flush_o
`endif
);

    fetch_state_e         state_d, state_q;
    logic [WordWidth-1:0] pc_d, pc_q;
    logic                 take, load, flush;

    assign take = !bus.if_valid || bus.id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = bus.redirect_valid && (state_q != FetchBoot);
        case (state_q)
            FetchBoot: state_d = bus.halt_req ? FetchHalted : FetchRun;
            FetchRun: begin
                if (bus.halt_req) begin
                    state_d = FetchHalted;
                end else if (!bus.redirect_valid && take) begin
                    load = 1'b1;
                end
            end
            FetchHalted: begin
                if (!bus.redirect_valid && !bus.halt_req && bus.resume) begin
                    state_d = FetchRun;
                end
            end
            default: state_d = FetchBoot;
        endcase
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (load) begin
            pc_d = pc_inc(pc_q, PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FetchBoot;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign fetch_state_o = state_q;

    if_id_reg #(
        .Width(WordWidth)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .load_i   (load),
        .ready_i  (bus.id_ready),
        .instr_i  (bus.imem_instr),
        .pc_i     (pc_q),
        .pc_next_i(pc_inc(pc_q, PC_STEP)),
        .valid_o  (bus.if_valid),
        .instr_o  (bus.if_instr),
        .pc_o     (bus.if_pc),
        .pc_next_o(bus.if_pc_next)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q;
    logic [15:0] flush_cnt_q;

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q   <= '0;
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load && (fetched_q != '1)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if ((state_q == FetchRun) && bus.if_valid && !bus.id_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (bus.redirect_valid && bus.if_valid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_stall_o   = stall_q;
    assign perf_flush_o   = flush_cnt_q;
`else
    // Counters compiled out.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a
// behavioural model of the fetch rules.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [15:0] perf_flush;
`endif

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC(32'h0),
        .PC_STEP (32'd1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .fetch_state_o(fetch_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_stall_o  (perf_stall),
        .perf_flush_o  (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    assign bus.imem_instr = 32'hA500_0000 | bus.imem_addr;

    // Reference model: mode 0=boot, 1=run, 2=halted.
    int          m_st;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipcn;
    logic        m_valid;
    int unsigned m_fetched, m_stall, m_flush;

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_valid = 1'b0;
        m_instr = '0; m_ipc = '0; m_ipcn = '0;
        m_fetched = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt_req       = 1'b0;
        bus.resume         = 1'b0;
        bus.id_ready       = 1'b1;
    endtask

    // Advance model and DUT by one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        int          nst;
        logic [31:0] npc;
        logic        nv, cap, take;
        nst = m_st; npc = m_pc; nv = m_valid; cap = 1'b0;
        take = !m_valid || bus.id_ready;
        if (m_st == 0) begin
            nst = bus.halt_req ? 2 : 1;
        end else if (m_st == 1) begin
            if (bus.halt_req) begin
                nst = 2;
                if (m_valid && bus.id_ready) nv = 1'b0;
            end else if (!bus.redirect_valid && take) begin
                cap = 1'b1;
            end
        end else begin
            if (!bus.redirect_valid && !bus.halt_req && bus.resume) nst = 1;
            if (m_valid && bus.id_ready) nv = 1'b0;
        end
        if (m_st == 1 && m_valid && !bus.id_ready) m_stall++;
        if (bus.redirect_valid && m_valid) m_flush++;
        if (cap) begin
            nv = 1'b1;
            m_instr = 32'hA500_0000 | m_pc;
            m_ipc = m_pc;
            m_ipcn = m_pc + 32'd1;
            npc = m_pc + 32'd1;
            m_fetched++;
        end
        if (bus.redirect_valid) begin
            npc = bus.redirect_pc;
            if (m_st != 0) nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_st = nst; m_pc = npc; m_valid = nv;
    endtask

    task automatic test_reset();
        set_idle();
        model_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (bus.if_valid !== 1'b0 || fetch_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state valid=%b state=%0d want valid=0 state=0",
                     bus.if_valid, fetch_state);
        end
        n_vec++;
        if (bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_pc_next !== 32'h0
            || bus.imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs instr=%h pc=%h pcn=%h addr=%h want all 0",
                     bus.if_instr, bus.if_pc, bus.if_pc_next, bus.imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (fetch_state !== 2'd1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL boot_cycle state=%0d valid=%b addr=%h want 1 0 0",
                     fetch_state, bus.if_valid, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i)
                || bus.if_instr !== (32'hA500_0000 + 32'(i))) begin
                n_err++;
                $display("FAIL stream[%0d] valid=%b pc=%h instr=%h want 1 %h %h", i,
                         bus.if_valid, bus.if_pc, bus.if_instr, i, 32'hA500_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h3 || bus.if_instr !== 32'hA500_0003
                || bus.imem_addr !== 32'h4) begin
                n_err++;
                $display("FAIL stall[%0d] valid=%b pc=%h instr=%h addr=%h want 1 3 a5000003 4",
                         i, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr);
            end
        end
        bus.id_ready = 1'b1;
        for (int i = 4; i < 6; i++) begin
            step();
            n_vec++;
            if (bus.if_pc !== 32'(i) || bus.if_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_release pc=%h valid=%b want %h 1", bus.if_pc,
                         bus.if_valid, i);
            end
        end
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL redirect_flush valid=%b addr=%h want 0 40", bus.if_valid,
                     bus.imem_addr);
        end
        step();
        n_vec++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_pc_next !== 32'h41
            || bus.if_instr !== 32'hA500_0040) begin
            n_err++;
            $display("FAIL redirect_target valid=%b pc=%h pcn=%h instr=%h want 1 40 41 a5000040",
                     bus.if_valid, bus.if_pc, bus.if_pc_next, bus.if_instr);
        end
    endtask

    task automatic test_halt_resume();
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        n_vec++;
        if (bus.if_valid !== 1'b0 || fetch_state !== 2'd2 || bus.imem_addr !== 32'h41) begin
            n_err++;
            $display("FAIL halt_entry valid=%b state=%0d addr=%h want 0 2 41",
                     bus.if_valid, fetch_state, bus.imem_addr);
        end
        step();
        step();
        n_vec++;
        if (fetch_state !== 2'd2 || bus.imem_addr !== 32'h41 || bus.if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_hold state=%0d addr=%h valid=%b want 2 41 0",
                     fetch_state, bus.imem_addr, bus.if_valid);
        end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        n_vec++;
        if (fetch_state !== 2'd1 || bus.if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL resume state=%0d valid=%b want 1 0", fetch_state, bus.if_valid);
        end
        step();
        n_vec++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h41) begin
            n_err++;
            $display("FAIL resume_capture valid=%b pc=%h want 1 41", bus.if_valid, bus.if_pc);
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        step();
        n_vec++;
        if (bus.if_pc !== 32'hFFFF_FFFF || bus.if_pc_next !== 32'h0 || bus.imem_addr !== 32'h0)
        begin
            n_err++;
            $display("FAIL wrap pc=%h pcn=%h addr=%h want ffffffff 0 0", bus.if_pc,
                     bus.if_pc_next, bus.imem_addr);
        end
        step();
        n_vec++;
        if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'hA500_0000) begin
            n_err++;
            $display("FAIL wrap_next pc=%h instr=%h want 0 a5000000", bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_pc    = $urandom();
            bus.halt_req       = ($urandom_range(0, 9) == 0);
            bus.resume         = ($urandom_range(0, 3) == 0);
            bus.id_ready       = ($urandom_range(0, 9) < 7);
            step();
            n_vec++;
            if (bus.if_valid !== m_valid || bus.imem_addr !== m_pc || fetch_state !== 2'(m_st)
                || bus.if_instr !== m_instr || bus.if_pc !== m_ipc || bus.if_pc_next !== m_ipcn)
            begin
                n_err++;
                $display("FAIL random[%0d] got v=%b a=%h s=%0d i=%h p=%h n=%h want %b %h %0d %h %h %h",
                         i, bus.if_valid, bus.imem_addr, fetch_state, bus.if_instr, bus.if_pc,
                         bus.if_pc_next, m_valid, m_pc, m_st, m_instr, m_ipc, m_ipcn);
            end
`ifdef FETCH_PERF_CNT_EN
            n_vec++;
            if (perf_fetched !== m_fetched || perf_stall !== m_stall
                || perf_flush !== 16'(m_flush)) begin
                n_err++;
                $display("FAIL random_perf[%0d] got %0d %0d %0d want %0d %0d %0d", i,
                         perf_fetched, perf_stall, perf_flush, m_fetched, m_stall, m_flush);
            end
`endif
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        set_idle();
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        step();
        step();
        bus.id_ready = 1'b0;
        step();
        n_vec++;
        if (bus.if_valid !== 1'b1 || m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_valid got %b model %b want 1", bus.if_valid, m_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0
            || bus.if_pc_next !== 32'h0 || bus.imem_addr !== 32'h0 || fetch_state !== 2'd0)
        begin
            n_err++;
            $display("FAIL async_reset v=%b i=%h p=%h n=%h a=%h s=%0d want all 0",
                     bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_next, bus.imem_addr,
                     fetch_state);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0 || perf_flush !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset_perf got %0d %0d %0d want 0 0 0", perf_fetched,
                     perf_stall, perf_flush);
        end
`endif
        bus.id_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        n_vec++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'hA500_0000) begin
            n_err++;
            $display("FAIL post_reset valid=%b pc=%h instr=%h want 1 0 a5000000",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt_resume();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
